pc_control: RTL and testbench
=============================

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have no parameters: PC width fixed at 16, flag width fixed at 3.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset; no other clock or reset exists in the block.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous reset, active low.
REQ-005 flags  input  3  current flags from flag register: [0]=Z, [1]=V, [2]=N.
REQ-006 branch  input  1  decoded B instruction (PC-relative).
REQ-007 branch_reg  input  1  decoded BR instruction (register target).
REQ-008 cond  input  3  branch condition code.
REQ-009 imm9  input  9  signed word offset for B.
REQ-010 reg_target  input  16  target address for BR.
REQ-011 halt_instr  input  1  decoded HLT instruction.
REQ-012 stall  input  1  hold PC this cycle.
REQ-013 pc  output  16  current PC, registered.
REQ-014 pc_plus2  output  16  pc + 2, combinational.
REQ-015 taken  output  1  branch taken this cycle, combinational.
REQ-016 flush  output  1  registered one-cycle pulse, asserted the cycle after a taken branch is committed.
REQ-017 hlt  output  1  registered, high while in HALTED state.

Function
REQ-018 pc_plus2 SHALL be pc + 16'h0002 modulo 2^16 (0xFFFE -> 0x0000).
REQ-019 Condition truth SHALL be: 000 Z=0; 001 Z=1; 010 Z=0 and N=0; 011 N=1; 100 Z=1 or (Z=0 and N=0); 101 N=1 or Z=1; 110 V=1; 111 always.
REQ-020 taken SHALL be (branch or branch_reg) and condition true and state RUN and not stall.
REQ-021 B target SHALL be pc_plus2 + (sign_extend(imm9) << 1), 16-bit modulo arithmetic.
REQ-022 BR target SHALL be reg_target unmodified.
REQ-023 If branch and branch_reg are both high, branch_reg SHALL win.
REQ-024 State machine SHALL have two states: RUN and HALTED.
REQ-025 In RUN with stall=1: pc holds, state holds, flush next cycle = 0; all other inputs ignored.
REQ-026 In RUN with stall=0, priority SHALL be halt_instr > taken > sequential.
REQ-027 In RUN, stall=0, halt_instr=1: pc holds, next state HALTED, no branch taken even if branch asserted.
REQ-028 In RUN, stall=0, taken=1: next pc = selected target, flush=1 on next cycle only.
REQ-029 In RUN, stall=0, no halt, not taken: next pc = pc_plus2.
REQ-030 HALTED SHALL be absorbing: pc frozen, hlt=1, taken=0, flush=0; exit only via reset.
REQ-031 flush SHALL never be high two consecutive cycles unless two consecutive taken branches commit.
REQ-032 Flag inputs SHALL be sampled combinationally in the same cycle as the branch; no internal flag copy.

Reset
REQ-033 On rst_n low, asynchronously and without waiting for clk: pc=0x0000, state=RUN, hlt=0, flush=0.
REQ-034 Reset asserted mid-branch or while HALTED SHALL override all; first post-reset rising edge with stall=0 and no branch/halt SHALL produce pc=0x0002.

Verification
REQ-035 Reset, then 3 cycles with no control inputs -> pc 0x0000, 0x0002, 0x0004, 0x0006; flush=0, hlt=0.
REQ-036 pc=0x0010, branch=1, cond=001, flags=3'b001, imm9=9'h1FE (-2) -> taken=1, next pc=0x000E, flush=1 one cycle; same with flags=3'b000 -> taken=0, next pc=0x0012.
REQ-037 pc=0x0020, branch_reg=1, cond=111, reg_target=0xABCD, stall=1 for 2 cycles then 0 -> pc holds 0x0020 twice, then 0xABCD, flush pulse once.
REQ-038 pc=0x0030, halt_instr=1 and branch=1 cond=111 same cycle -> pc stays 0x0030, hlt=1 next cycle and thereafter, taken=0; then rst_n low -> pc=0x0000, hlt=0 immediately.
REQ-039 pc=0xFFFE sequential -> 0x0000; pc=0x0000, branch, cond=110, flags=3'b010, imm9=9'h0FF -> next pc=0x0200.
REQ-040 Sweep all 8 cond codes x 8 flag values -> taken matches REQ-019 table exactly.

Source files
------------

// File: rtl/pc_control.sv
// pc_control: program counter sequencing with conditional branching and halt.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flags       current flags: [0]=Z, [1]=V, [2]=N (sampled combinationally)
//   branch      decoded B (PC-relative) instruction
//   branch_reg  decoded BR (register target) instruction; wins over branch
//   cond        3-bit branch condition code
//   imm9        signed word offset for B
//   reg_target  absolute target for BR
//   halt_instr  decoded HLT instruction
//   stall       hold PC and state this cycle
//   pc          current PC (registered)
//   pc_plus2    pc + 2 (combinational, wraps)
//   taken       branch taken this cycle (combinational)
//   flush       one-cycle pulse the cycle after a taken branch commits
//   hlt         high while halted
module pc_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  flags,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic [2:0]  cond,
    input  logic [8:0]  imm9,
    input  logic [15:0] reg_target,
    input  logic        halt_instr,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic        flush,
    output logic        hlt
);

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        flush_q, flush_d;

    logic        flag_z, flag_v, flag_n;
    logic        cond_true;
    logic [15:0] b_offset;
    logic [15:0] target;

    assign flag_z = flags[0];
    assign flag_v = flags[1];
    assign flag_n = flags[2];

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = !flag_z;
            3'b001: cond_true = flag_z;
            3'b010: cond_true = !flag_z && !flag_n;
            3'b011: cond_true = flag_n;
            3'b100: cond_true = flag_z || (!flag_z && !flag_n);
            3'b101: cond_true = flag_n || flag_z;
            3'b110: cond_true = flag_v;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign pc_plus2 = pc_q + 16'h0002;

    // Word offset: sign-extend and scale by two bytes.
    assign b_offset = {{6{imm9[8]}}, imm9, 1'b0};
    assign target   = branch_reg ? reg_target : (pc_plus2 + b_offset);

    // Halt outranks any branch in the same cycle, so it suppresses taken too.
    assign taken = (branch || branch_reg) && cond_true && (state_q == StRun)
                   && !stall && !halt_instr;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!stall) begin
                    if (halt_instr) begin
                        state_d = StHalted;
                    end else if (taken) begin
                        pc_d    = target;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
            end
            StHalted: begin
                // Absorbing: only reset leaves this state.
                state_d = StHalted;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            pc_q    <= 16'h0000;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign pc    = pc_q;
    assign flush = flush_q;
    assign hlt   = (state_q == StHalted);

endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed self-checking bench for pc_control with a scoreboard
// of expected post-edge state pushed at drive time and popped after each edge.
module tb_pc_control;

    logic        clk;
    logic        rst_n;
    logic [2:0]  flags;
    logic        branch;
    logic        branch_reg;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] reg_target;
    logic        halt_instr;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        flush;
    logic        hlt;

    pc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flags      (flags),
        .branch     (branch),
        .branch_reg (branch_reg),
        .cond       (cond),
        .imm9       (imm9),
        .reg_target (reg_target),
        .halt_instr (halt_instr),
        .stall      (stall),
        .pc         (pc),
        .pc_plus2   (pc_plus2),
        .taken      (taken),
        .flush      (flush),
        .hlt        (hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        flush;
        logic        hlt;
    } exp_t;

    exp_t        sb[$];
    int          tests;
    int          fails;
    logic [15:0] m_pc;
    logic        m_halt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Condition table written out directly: Z=f[0], V=f[1], N=f[2].
    function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[0];
        v = f[1];
        n = f[2];
        case (c)
            3'd0: return z == 1'b0;
            3'd1: return z == 1'b1;
            3'd2: return (z == 1'b0) && (n == 1'b0);
            3'd3: return n == 1'b1;
            3'd4: return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
            3'd5: return (n == 1'b1) || (z == 1'b1);
            3'd6: return v == 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    // Drive one cycle's inputs, check combinational outputs, push the expected
    // registered state, clock, then pop and compare.
    task automatic cycle(input logic br, input logic brr, input logic [2:0] c,
                         input logic [2:0] fl, input logic [8:0] imm,
                         input logic [15:0] tgt, input logic hi, input logic stl,
                         input string tag);
        logic        exp_taken;
        logic [15:0] tgt_m;
        exp_t        e;
        exp_t        got;
        branch     = br;
        branch_reg = brr;
        cond       = c;
        flags      = fl;
        imm9       = imm;
        reg_target = tgt;
        halt_instr = hi;
        stall      = stl;
        #1;
        exp_taken = !m_halt && !stl && !hi && (br || brr) && cond_ref(c, fl);
        tgt_m     = brr ? tgt : (m_pc + 16'd2 + {{6{imm[8]}}, imm, 1'b0});
        chk({tag, ".taken"}, {15'd0, taken}, {15'd0, exp_taken});
        chk({tag, ".pc_plus2"}, pc_plus2, m_pc + 16'd2);
        e.flush = 1'b0;
        if (m_halt || stl) begin
            e.pc = m_pc;
        end else if (hi) begin
            e.pc   = m_pc;
            m_halt = 1'b1;
        end else if (exp_taken) begin
            e.pc    = tgt_m;
            e.flush = 1'b1;
        end else begin
            e.pc = m_pc + 16'd2;
        end
        e.hlt = m_halt;
        m_pc  = e.pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({tag, ".pc"}, pc, got.pc);
            chk({tag, ".flush"}, {15'd0, flush}, {15'd0, got.flush});
            chk({tag, ".hlt"}, {15'd0, hlt}, {15'd0, got.hlt});
        end
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000, 1'b0, 1'b0, tag);
    endtask

    task automatic jump(input logic [15:0] tgt, input string tag);
        cycle(1'b0, 1'b1, 3'd7, 3'd0, 9'd0, tgt, 1'b0, 1'b0, tag);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        flags      = 3'd0;
        branch     = 1'b0;
        branch_reg = 1'b0;
        cond       = 3'd0;
        imm9       = 9'd0;
        reg_target = 16'h0000;
        halt_instr = 1'b0;
        stall      = 1'b0;
        m_pc       = 16'h0000;
        m_halt     = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst.pc", pc, 16'h0000);
        chk("rst.flush", {15'd0, flush}, 16'd0);
        chk("rst.hlt", {15'd0, hlt}, 16'd0);
        rst_n = 1'b1;

        // Sequential from reset
        idle("seq0");
        idle("seq1");
        idle("seq2");

        // B taken backwards, then not taken
        jump(16'h0010, "br10a");
        cycle(1'b1, 1'b0, 3'd1, 3'b001, 9'h1FE, 16'h0000, 1'b0, 1'b0, "b_taken");
        idle("after_b");
        jump(16'h0010, "br10b");
        cycle(1'b1, 1'b0, 3'd1, 3'b000, 9'h1FE, 16'h0000, 1'b0, 1'b0, "b_ntaken");

        // BR with stall for two cycles
        jump(16'h0020, "br20");
        cycle(1'b0, 1'b1, 3'd7, 3'd0, 9'd0, 16'hABCD, 1'b0, 1'b1, "stall0");
        cycle(1'b0, 1'b1, 3'd7, 3'd0, 9'd0, 16'hABCD, 1'b0, 1'b1, "stall1");
        cycle(1'b0, 1'b1, 3'd7, 3'd0, 9'd0, 16'hABCD, 1'b0, 1'b0, "br_abcd");
        idle("after_br");

        // Both branch kinds high: register target wins
        cycle(1'b1, 1'b1, 3'd7, 3'd0, 9'h004, 16'h1234, 1'b0, 1'b0, "both");

        // Wrap and large positive offset
        jump(16'hFFFE, "brfffe");
        idle("wrap");
        cycle(1'b1, 1'b0, 3'd6, 3'b010, 9'h0FF, 16'h0000, 1'b0, 1'b0, "b_0ff");

        // Condition sweep; imm9=0 so either outcome lands on pc+2
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cycle(1'b1, 1'b0, 3'(c), 3'(f), 9'd0, 16'h0000, 1'b0, 1'b0, "sweep");
            end
        end

        // Halt beats a simultaneous always-branch; halted state is absorbing
        jump(16'h0030, "br30");
        cycle(1'b1, 1'b0, 3'd7, 3'd0, 9'h010, 16'h0000, 1'b1, 1'b0, "halt");
        idle("halted0");
        cycle(1'b0, 1'b1, 3'd7, 3'd0, 9'd0, 16'h5555, 1'b0, 1'b0, "halted_br");

        // Asynchronous reset while halted, mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pc", pc, 16'h0000);
        chk("arst.hlt", {15'd0, hlt}, 16'd0);
        chk("arst.flush", {15'd0, flush}, 16'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_pc   = 16'h0000;
        m_halt = 1'b0;
        idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
